// File: rtl/team_06_lcd_driver_if.sv
`default_nettype none
//============================================================================
// Module      : team_06_lcd_driver_if
// Description : Bundle between the display-content logic, the HD44780 LCD
//               driver and the LCD pins. The master modport is the driver
//               side; the slave modport is the surrounding system side.
// Revision    : 1.0 - initial release
//============================================================================
interface team_06_lcd_driver_if;
   logic [127:0] row_1;
   logic [127:0] row_2;
   logic         lcd_rs;
   logic         lcd_rw;
   logic         lcd_en;
   logic [7:0]   lcd_data;
   logic         init_done;
   logic         frame_done;

   modport master (
      input  row_1, row_2,
      output lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, frame_done
   );

   modport slave (
      output row_1, row_2,
      input  lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/team_06_lcd_driver.sv
`default_nettype none
//============================================================================
// Module      : team_06_lcd_driver
// Description : 16x2 HD44780 character LCD driver, 8-bit write-only bus.
//               Runs the power-up init sequence once, then loops forever:
//               snapshot both rows, write row 1, write row 2. All timing is
//               counter based; the busy flag is never read.
// Option      : LCD_SKIP_UNCHANGED_EN - when defined, a frame is only
//               written if the row inputs differ from the last snapshot.
// Revision    : 1.0 - initial release
//============================================================================
module team_06_lcd_driver #(
   parameter int unsigned INIT_WAIT_CYCLES  = 150000,
   parameter int unsigned EN_PULSE_CYCLES   = 10,
   parameter int unsigned CMD_WAIT_CYCLES   = 500,
   parameter int unsigned CLEAR_WAIT_CYCLES = 20000
) (
   input  logic                        clk,
   input  logic                        rst,
   team_06_lcd_driver_if.master        lcd
);

   // Counter width covers the largest of all wait parameters.
   localparam int unsigned c_MAX_AB = (INIT_WAIT_CYCLES > EN_PULSE_CYCLES) ?
                                      INIT_WAIT_CYCLES : EN_PULSE_CYCLES;
   localparam int unsigned c_MAX_CD = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ?
                                      CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
   localparam int unsigned c_MAX    = (c_MAX_AB > c_MAX_CD) ? c_MAX_AB : c_MAX_CD;
   localparam int          c_CW     = (c_MAX < 2) ? 1 : $clog2(c_MAX + 1);

   // Terminal counts; a zero parameter still yields a one-cycle phase.
   localparam logic [c_CW-1:0] c_PWR_LAST   = c_CW'((INIT_WAIT_CYCLES  == 0) ? 0 : INIT_WAIT_CYCLES  - 1);
   localparam logic [c_CW-1:0] c_PULSE_LAST = c_CW'((EN_PULSE_CYCLES   == 0) ? 0 : EN_PULSE_CYCLES   - 1);
   localparam logic [c_CW-1:0] c_CMD_LAST   = c_CW'((CMD_WAIT_CYCLES   == 0) ? 0 : CMD_WAIT_CYCLES   - 1);
   localparam logic [c_CW-1:0] c_CLR_LAST   = c_CW'((CLEAR_WAIT_CYCLES == 0) ? 0 : CLEAR_WAIT_CYCLES - 1);

   // Top-level states
   localparam logic [2:0] S_PWR   = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_SNAP  = 3'd2;
   localparam logic [2:0] S_ADDR1 = 3'd3;
   localparam logic [2:0] S_ROW1  = 3'd4;
   localparam logic [2:0] S_ADDR2 = 3'd5;
   localparam logic [2:0] S_ROW2  = 3'd6;

   // Byte-write phases
   localparam logic [1:0] PH_SETUP = 2'd0;
   localparam logic [1:0] PH_PULSE = 2'd1;
   localparam logic [1:0] PH_HOLD  = 2'd2;

   logic [2:0]      r_state;
   logic [1:0]      r_ph;
   logic [c_CW-1:0] r_cnt;
   logic [2:0]      r_step;
   logic [3:0]      r_idx;
   logic [255:0]    r_snap;
   logic            r_init_done;
   logic            r_frame_done;
`ifdef LCD_SKIP_UNCHANGED_EN
   logic            r_snap_vld;
`endif

   logic [127:0]    w_row1;
   logic [127:0]    w_row2;
   logic [7:0]      w_byte;
   logic            w_rs;
   logic            w_in_byte;
   logic [c_CW-1:0] w_hold_last;
   logic            w_start_frame;

   assign w_row1 = r_snap[255:128];
   assign w_row2 = r_snap[127:0];

   // Byte currently on the bus, decoded from state; stable for the whole byte.
   always_comb begin
      w_byte    = 8'h00;
      w_rs      = 1'b0;
      w_in_byte = 1'b1;
      case (r_state)
         S_INIT: begin
            case (r_step)
               3'd0, 3'd1, 3'd2, 3'd3: w_byte = 8'h38;
               3'd4:                   w_byte = 8'h0C;
               3'd5:                   w_byte = 8'h01;
               default:                w_byte = 8'h06;
            endcase
         end
         S_ADDR1: w_byte = 8'h80;
         S_ROW1: begin
            w_rs   = 1'b1;
            // column i lives at [127-8i -: 8], i.e. base 8*(15-i)
            w_byte = w_row1[{~r_idx, 3'b000} +: 8];
         end
         S_ADDR2: w_byte = 8'hC0;
         S_ROW2: begin
            w_rs   = 1'b1;
            w_byte = w_row2[{~r_idx, 3'b000} +: 8];
         end
         default: w_in_byte = 1'b0;
      endcase
   end

   // The clear command needs a much longer post-wait than every other byte.
   assign w_hold_last = ((r_state == S_INIT) && (r_step == 3'd5)) ? c_CLR_LAST : c_CMD_LAST;

   // In SNAP, decide whether a new frame is written this cycle.
`ifdef LCD_SKIP_UNCHANGED_EN
   assign w_start_frame = !(r_snap_vld && r_init_done &&
                            ({lcd.row_1, lcd.row_2} == r_snap));
`else
   assign w_start_frame = 1'b1;
`endif

   // Main sequencer: power wait, init commands, frame loop, byte timing.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_PWR;
         r_ph         <= PH_SETUP;
         r_cnt        <= '0;
         r_step       <= 3'd0;
         r_idx        <= 4'd0;
         r_snap       <= '0;
         r_init_done  <= 1'b0;
         r_frame_done <= 1'b0;
`ifdef LCD_SKIP_UNCHANGED_EN
         r_snap_vld   <= 1'b0;
`endif
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_PWR: begin
               if (r_cnt == c_PWR_LAST) begin
                  r_cnt   <= '0;
                  r_step  <= 3'd0;
                  r_ph    <= PH_SETUP;
                  r_state <= S_INIT;
               end else begin
                  r_cnt <= r_cnt + c_CW'(1);
               end
            end
            S_SNAP: begin
               if (w_start_frame) begin
                  r_snap  <= {lcd.row_1, lcd.row_2};
                  r_idx   <= 4'd0;
                  r_cnt   <= '0;
                  r_ph    <= PH_SETUP;
                  r_state <= S_ADDR1;
`ifdef LCD_SKIP_UNCHANGED_EN
                  r_snap_vld <= 1'b1;
`endif
               end
            end
            default: begin
               case (r_ph)
                  PH_SETUP: begin
                     r_cnt <= '0;
                     r_ph  <= PH_PULSE;
                  end
                  PH_PULSE: begin
                     if (r_cnt == c_PULSE_LAST) begin
                        r_cnt <= '0;
                        r_ph  <= PH_HOLD;
                     end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                     end
                  end
                  default: begin
                     if (r_cnt == w_hold_last) begin
                        r_cnt <= '0;
                        r_ph  <= PH_SETUP;
                        case (r_state)
                           S_INIT: begin
                              if (r_step == 3'd6) begin
                                 r_init_done <= 1'b1;
                                 r_state     <= S_SNAP;
                              end else begin
                                 r_step <= r_step + 3'd1;
                              end
                           end
                           S_ADDR1: begin
                              r_idx   <= 4'd0;
                              r_state <= S_ROW1;
                           end
                           S_ROW1: begin
                              r_idx <= r_idx + 4'd1;
                              if (r_idx == 4'd15) r_state <= S_ADDR2;
                           end
                           S_ADDR2: begin
                              r_idx   <= 4'd0;
                              r_state <= S_ROW2;
                           end
                           S_ROW2: begin
                              r_idx <= r_idx + 4'd1;
                              if (r_idx == 4'd15) begin
                                 r_frame_done <= 1'b1;
                                 r_state      <= S_SNAP;
                              end
                           end
                           default: r_state <= S_PWR;
                        endcase
                     end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                     end
                  end
               endcase
            end
         endcase
      end
   end

   assign lcd.lcd_rs     = w_rs;
   assign lcd.lcd_rw     = 1'b0;
   assign lcd.lcd_en     = w_in_byte && (r_ph == PH_PULSE);
   assign lcd.lcd_data   = w_byte;
   assign lcd.init_done  = r_init_done;
   assign lcd.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_team_06_lcd_driver.sv
`default_nettype none
//============================================================================
// Module      : tb_team_06_lcd_driver
// Description : Scoreboard bench for team_06_lcd_driver with small timing
//               parameters. Expected bus bytes are queued by the stimulus
//               and popped by a monitor on every lcd_en falling edge.
// Revision    : 1.0 - initial release
//============================================================================
module tb_team_06_lcd_driver;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   team_06_lcd_driver_if lif ();

   team_06_lcd_driver #(
      .INIT_WAIT_CYCLES (20),
      .EN_PULSE_CYCLES  (2),
      .CMD_WAIT_CYCLES  (3),
      .CLEAR_WAIT_CYCLES(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .lcd(lif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   localparam logic [127:0] ROW_ECHO   = {8'h45, 8'h43, 8'h48, 8'h4F, {12{8'h20}}};
   localparam logic [127:0] ROW_LISTEN = {8'h4C, 8'h49, 8'h53, 8'h54, 8'h45, 8'h4E, {10{8'h20}}};
   localparam logic [127:0] ROW_FF     = {16{8'hFF}};

   logic [8:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   bit abort = 1'b0;
   bit gap_chk = 1'b1;
   int last_fall_cyc = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_init();
      exp_q.push_back(9'h038); exp_q.push_back(9'h038);
      exp_q.push_back(9'h038); exp_q.push_back(9'h038);
      exp_q.push_back(9'h00C); exp_q.push_back(9'h001);
      exp_q.push_back(9'h006);
   endtask

   task automatic push_frame(input logic [127:0] r1, input logic [127:0] r2);
      exp_q.push_back(9'h080);
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, r1[127-8*i -: 8]});
      exp_q.push_back(9'h0C0);
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, r2[127-8*i -: 8]});
   endtask

   // Monitor: pulse width, bus stability, inter-byte gap and byte content.
   logic       m_prev_en = 1'b0;
   logic [8:0] m_prev_byte = '0;
   logic [8:0] m_rise_byte = '0;
   logic [8:0] m_last_byte = '0;
   int         m_hi = 0;
   int         m_lo = 0;
   bit         m_have_fall = 1'b0;
   always @(negedge clk) begin : monitor
      logic [8:0] cur;
      cur = {lif.lcd_rs, lif.lcd_data};
      if (lif.lcd_en && !m_prev_en) begin
         m_hi        = 1;
         m_rise_byte = cur;
         check("setup_stable", cur, m_prev_byte);
         if (gap_chk && m_have_fall)
            check("gap", m_lo, (m_last_byte == 9'h001) ? 9 : ((cur == 9'h080) ? 5 : 4));
      end else if (lif.lcd_en) begin
         m_hi++;
      end else if (m_prev_en) begin
         if (abort) begin
            m_have_fall = 1'b0;
         end else begin
            check("en_width", m_hi, 2);
            check("pulse_stable", cur, m_rise_byte);
            if (exp_q.size() == 0) check("unexpected_byte", cur, -1);
            else                   check("byte", cur, exp_q.pop_front());
            m_have_fall   = 1'b1;
            m_lo          = 1;
            m_last_byte   = cur;
            last_fall_cyc = cyc;
         end
      end else begin
         m_lo++;
      end
      m_prev_en   = lif.lcd_en;
      m_prev_byte = cur;
   end

   task automatic time_first_en(output int n);
      n = 0;
      while (!lif.lcd_en && n < 300) begin
         @(posedge clk); #1;
         n++;
         abort = 1'b0;
      end
   endtask

   task automatic wait_rises(input int k);
      logic prev;
      int   cnt, n;
      prev = lif.lcd_en; cnt = 0; n = 0;
      while (cnt < k && n < 3000) begin
         @(posedge clk); #1;
         n++;
         if (lif.lcd_en && !prev) cnt++;
         prev = lif.lcd_en;
      end
      if (cnt < k) check("wait_rises_timeout", cnt, k);
   endtask

   task automatic wait_fd(output int at, output int width);
      int n;
      at = -1; width = 0; n = 0;
      while (!lif.frame_done && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!lif.frame_done) begin
         check("frame_done_timeout", 0, 1);
      end else begin
         at = cyc;
         while (lif.frame_done && width < 10) begin
            width++;
            @(posedge clk); #1;
         end
      end
   endtask

   // Stimulus: drives rows and reset, queues the expected byte stream.
   initial begin : stim
      int n, fd_a, fd_b, w;
      rst = 1'b1;
      lif.row_1 = ROW_ECHO;
      lif.row_2 = ROW_FF;
      push_init();
      push_frame(ROW_ECHO, ROW_FF);
`ifndef LCD_SKIP_UNCHANGED_EN
      push_frame(ROW_ECHO, ROW_FF);
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_en",         lif.lcd_en,     0);
      check("rst_rs",         lif.lcd_rs,     0);
      check("rst_rw",         lif.lcd_rw,     0);
      check("rst_data",       lif.lcd_data,   0);
      check("rst_init_done",  lif.init_done,  0);
      check("rst_frame_done", lif.frame_done, 0);
      rst = 1'b0;

      time_first_en(n);
      check("first_en_rise", n, 21);

      n = 0;
      while (!lif.init_done && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check("init_done_seen", lif.init_done, 1);
      check("init_done_delay", cyc - last_fall_cyc, 3);

`ifndef LCD_SKIP_UNCHANGED_EN
      wait_fd(fd_a, w);
      check("fd1_width", w, 1);
      check("q_after_frame1", exp_q.size(), 34);

      // change row_1 while ROW1 column 5 is on the bus
      wait_rises(7);
      check("col5_byte", {lif.lcd_rs, lif.lcd_data}, 9'h120);
      lif.row_1 = ROW_LISTEN;
      push_frame(ROW_LISTEN, ROW_FF);

      wait_fd(fd_b, w);
      check("fd2_width", w, 1);
      check("frame_len", fd_b - fd_a, 205);
      check("q_after_frame2", exp_q.size(), 34);

      // reset during the PULSE of ROW2 column 1
      wait_rises(20);
      abort = 1'b1;
      rst   = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_en",         lif.lcd_en,     0);
      check("midrst_data",       lif.lcd_data,   0);
      check("midrst_init_done",  lif.init_done,  0);
      check("midrst_frame_done", lif.frame_done, 0);
      check("midrst_q_left",     exp_q.size(),   15);
      exp_q.delete();
      push_init();
      push_frame(ROW_LISTEN, ROW_FF);
      time_first_en(n);
      check("replay_first_en_rise", n, 21);
      wait_fd(fd_a, w);
      check("replay_fd_width", w, 1);
      check("q_after_replay", exp_q.size(), 0);
`else
      wait_fd(fd_a, w);
      check("fd1_width", w, 1);
      check("q_after_frame1", exp_q.size(), 0);
      gap_chk = 1'b0;
      begin
         int rises, fds;
         logic prev;
         rises = 0; fds = 0; prev = lif.lcd_en;
         repeat (1000) begin
            @(posedge clk); #1;
            if (lif.lcd_en && !prev) rises++;
            if (lif.frame_done) fds++;
            prev = lif.lcd_en;
         end
         check("idle_rises", rises, 0);
         check("idle_frame_done", fds, 0);
      end
      lif.row_2[7:0] = 8'h20;
      push_frame(ROW_ECHO, {ROW_FF[127:8], 8'h20});
      time_first_en(n);
      check("skip_restart_delay", n, 2);
      wait_fd(fd_b, w);
      check("fd2_width", w, 1);
      check("q_after_frame2", exp_q.size(), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
